fetch_sequencer: RTL and testbench

//  Sequences the 16-bit RISC instruction memory: owns the program counter and drives it onto the memory's pc input.

---
 rtl/fetch_sequencer_pkg.sv | 22 ++
 rtl/fetch_sequencer.sv | 120 ++++++++++++
 tb/tb_fetch_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: default widths,
// PC step, fetch FSM state encoding and a saturating-increment helper.
package fetch_sequencer_pkg;

  localparam int DEF_PC_WIDTH    = 16;
  localparam int DEF_INSTR_WIDTH = 16;
  localparam int DEF_RESET_PC    = 0;
  localparam int DEF_PROG_WORDS  = 10;
  localparam int PC_STEP         = 2;   // instructions are two bytes apart

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the program counter, captures the
// instruction memory word into ir and offers it to decode. Supports start,
// decode stall, branch redirect and a terminal halt at end of program.
//
// Handshake: ir/ir_pc are offered while ir_valid is high; a transfer
// happens on every rising edge where ir_valid && ir_ready. While
// ir_valid is high and ir_ready is low, ir, ir_pc and ir_valid hold.
// A redirect squashes the offered word (ir_valid drops) but a transfer
// in that same cycle still completes and is counted.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int RESET_PC    = DEF_RESET_PC,
  parameter int PROG_WORDS  = DEF_PROG_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    imem_pc,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0]    ir_pc,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   halted,
  output logic [15:0]            retired_count
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] END_PC     = PC_WIDTH'(2 * PROG_WORDS);
  localparam logic [PC_WIDTH-1:0] LAST_PC    = END_PC - PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(1));

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] target;
  logic                advance;
  logic                accept;

  assign imem_pc = pc;
  assign advance = !ir_valid || ir_ready;
  assign accept  = ir_valid && ir_ready;

  // Next-pc candidates: sequential step (wraps naturally) and aligned branch target.
  always_comb begin
    pc_seq = pc + PC_WIDTH'(PC_STEP);
    target = redirect_pc & ALIGN_MASK;
  end

  // Fetch FSM and instruction register; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_IDLE;
      pc       <= RESET_PC_V;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (start) begin
            state <= FETCH_RUN;
          end
        end
        FETCH_RUN: begin
          if (redirect) begin
            // Branch wins over stall and over the end-of-program step.
            pc       <= target;
            ir_valid <= 1'b0;
            if (target >= END_PC) begin
              state  <= FETCH_HALT;
              halted <= 1'b1;
            end
          end else if (pc >= END_PC) begin
            // Out-of-program address: never issue, just stop.
            state  <= FETCH_HALT;
            halted <= 1'b1;
            if (accept) begin
              ir_valid <= 1'b0;
            end
          end else if (advance) begin
            ir       <= imem_instr;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            pc       <= pc_seq;
            if (pc == LAST_PC) begin
              state  <= FETCH_HALT;
              halted <= 1'b1;
            end
          end
        end
        FETCH_HALT: begin
          // Last issued word drains to decode; pc stays frozen.
          if (accept) begin
            ir_valid <= 1'b0;
          end
        end
        default: begin
          state <= FETCH_IDLE;
        end
      endcase
    end
  end

  // Count of words accepted by decode, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= 16'd0;
    end else if (accept) begin
      retired_count <= sat_inc16(retired_count);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: program table, directed corner sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_fetch_sequencer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;
  logic [15:0] retired_count;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halted        (halted),
    .retired_count (retired_count)
  );

  // Instruction memory stand-in: combinational read, word index pc[4:1].
  logic [15:0] mem [16];
  assign imem_instr = mem[imem_pc[4:1]];

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit sb_on = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Program-level view: is the sequencer fetching, has it stopped, where is
  // it pointing, what is decode being offered, how many words retired.
  bit          m_fetching;
  bit          m_stopped;
  logic [15:0] m_pc;
  bit          m_offer;
  logic [15:0] m_offer_pc;
  logic [15:0] m_offer_word;
  int          m_retired;

  function automatic void model_reset();
    m_fetching   = 1'b0;
    m_stopped    = 1'b0;
    m_pc         = 16'd0;
    m_offer      = 1'b0;
    m_offer_pc   = 16'd0;
    m_offer_word = 16'd0;
    m_retired    = 0;
  endfunction

  function automatic void model_step(input bit s, input bit r, input bit d, input logic [15:0] rp);
    bit taken;
    taken = m_offer && r;
    if (taken && m_retired < 65535) m_retired++;
    if (m_stopped) begin
      if (taken) m_offer = 1'b0;
    end else if (!m_fetching) begin
      if (s) m_fetching = 1'b1;
    end else if (d) begin
      m_pc    = {rp[15:1], 1'b0};
      m_offer = 1'b0;
      if (int'(m_pc) >= 20) m_stopped = 1'b1;
    end else if (!m_offer || r) begin
      m_offer_word = mem[int'(m_pc) / 2 % 16];
      m_offer_pc   = m_pc;
      m_offer      = 1'b1;
      m_pc         = m_pc + 16'd2;
      if (int'(m_offer_pc) == 18) m_stopped = 1'b1;
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".imem_pc"},  32'(imem_pc),       32'(m_pc));
    check({tag, ".ir_valid"}, 32'(ir_valid),      32'(m_offer));
    check({tag, ".ir_pc"},    32'(ir_pc),         32'(m_offer_pc));
    check({tag, ".ir"},       32'(ir),            32'(m_offer_word));
    check({tag, ".halted"},   32'(halted),        32'(m_stopped));
    check({tag, ".retired"},  32'(retired_count), 32'(m_retired));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive inputs now (away from the edge), scoreboard any
  // transfer about to happen, then compare with the model after the edge.
  task automatic cycle(input bit s, input bit r, input bit d, input logic [15:0] rp);
    start = s; ir_ready = r; redirect = d; redirect_pc = rp;
    #1;
    if (sb_on && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_accept", 32'(ir_pc), 32'hFFFF_FFFF);
      else check("sb_ir_pc", 32'(ir_pc), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    model_step(s, r, d, rp);
    #1;
    compare_model("cyc");
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'd0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_model("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run with decode always ready until word at addr is offered (bounded).
  task automatic run_until_ir_pc(input logic [15:0] addr);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      if (ir_valid && ir_pc == addr) found = 1'b1;
    end
    check("wait_ir_pc_timeout", 32'(found), 32'd1);
  endtask

  task automatic drain_to_halt();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      if (halted && !ir_valid) done = 1'b1;
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  // ---------------- table of program-sweep vectors ----------------
  typedef struct {
    bit          start;
    bit          ready;
    logic [15:0] exp_pc;
    bit          exp_valid;
    logic [15:0] exp_ir_pc;
    bit          exp_halted;
    logic [15:0] exp_retired;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input bit s, input bit r, input int pcv, input bit v,
                              input int ipc, input bit h, input int ret);
    vec_t x;
    x.start = s; x.ready = r; x.exp_pc = 16'(pcv); x.exp_valid = v;
    x.exp_ir_pc = 16'(ipc); x.exp_halted = h; x.exp_retired = 16'(ret);
    return x;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'd0;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    model_reset();
    repeat (2) @(negedge clk);
    compare_model("por");
    rst_n = 1'b1;

    // Straight program: fetch 0..18 with decode always ready.
    tbl[0] = mk(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 0);
    for (int k = 1; k <= 10; k++) tbl[k] = mk(1'b0, 1'b1, 2 * k, 1'b1, 2 * (k - 1), k == 10, k - 1);
    tbl[11] = mk(1'b0, 1'b1, 20, 1'b0, 18, 1'b1, 10);
    tbl[12] = mk(1'b1, 1'b1, 20, 1'b0, 18, 1'b1, 10);
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].start, tbl[i].ready, 1'b0, 16'd0);
      check("t1_imem_pc",  32'(imem_pc),       32'(tbl[i].exp_pc));
      check("t1_ir_valid", 32'(ir_valid),      32'(tbl[i].exp_valid));
      check("t1_ir_pc",    32'(ir_pc),         32'(tbl[i].exp_ir_pc));
      check("t1_halted",   32'(halted),        32'(tbl[i].exp_halted));
      check("t1_retired",  32'(retired_count), 32'(tbl[i].exp_retired));
      if (tbl[i].exp_valid) check("t1_ir", 32'(ir), 32'(mem[tbl[i].exp_ir_pc[4:1]]));
    end

    // Stall at ir_pc=4: everything holds, no word skipped or duplicated.
    do_reset();
    exp_q.delete();
    for (int a = 0; a < 20; a += 2) exp_q.push_back(16'(a));
    sb_on = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 16'd0);
    run_until_ir_pc(16'd4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'd0);
      check("t2_hold_ir_pc",   32'(ir_pc),    32'd4);
      check("t2_hold_imem_pc", 32'(imem_pc),  32'd6);
      check("t2_hold_valid",   32'(ir_valid), 32'd1);
      check("t2_hold_ir",      32'(ir),       32'(mem[2]));
    end
    cycle(1'b0, 1'b1, 1'b0, 16'd0);
    check("t2_resume_ir_pc", 32'(ir_pc), 32'd6);
    drain_to_halt();
    sb_on = 1'b0;
    check("t2_sb_leftover", 32'(exp_q.size()), 32'd0);
    check("t2_retired",     32'(retired_count), 32'd10);

    // Redirect while the branch at 16 is accepted: back to 8, run to halt.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 16'd0);
    run_until_ir_pc(16'd16);
    cycle(1'b0, 1'b1, 1'b1, 16'd8);
    check("t3_squash",   32'(ir_valid),      32'd0);
    check("t3_imem_pc",  32'(imem_pc),       32'd8);
    check("t3_retired",  32'(retired_count), 32'd9);
    cycle(1'b0, 1'b1, 1'b0, 16'd0);
    check("t3_target",   32'(ir_pc),         32'd8);
    drain_to_halt();
    check("t3_total",    32'(retired_count), 32'd15);

    // Odd targets: 7 -> fetch at 6; 21 -> pc 20 and halt; redirect/start in HALT ignored.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 1'b1, 1'b1, 16'd7);
    check("t4_align",    32'(imem_pc),  32'd6);
    cycle(1'b0, 1'b1, 1'b0, 16'd0);
    check("t4_fetch6",   32'(ir_pc),    32'd6);
    cycle(1'b0, 1'b1, 1'b1, 16'd21);
    check("t4_end_pc",   32'(imem_pc),  32'd20);
    check("t4_halted",   32'(halted),   32'd1);
    check("t4_no_valid", 32'(ir_valid), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 16'd4);
    check("t4_frozen",   32'(imem_pc),  32'd20);
    check("t4_still_off", 32'(ir_valid), 32'd0);

    // Redirect with stall while pc=18 is next: redirect wins, no halt.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 16'd0);
    run_until_ir_pc(16'd16);
    cycle(1'b0, 1'b0, 1'b1, 16'd10);
    check("t5_no_halt",  32'(halted),        32'd0);
    check("t5_imem_pc",  32'(imem_pc),       32'd10);
    check("t5_squash",   32'(ir_valid),      32'd0);
    check("t5_retired",  32'(retired_count), 32'd8);
    run_until_ir_pc(16'd16);
    cycle(1'b0, 1'b0, 1'b1, 16'd20);
    check("t5_halt_tgt", 32'(halted),        32'd1);

    // Reset mid-run with a word offered and pc=10; refetch from 0 afterwards.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 16'd0);
    run_until_ir_pc(16'd8);
    check("t6_pre_pc",    32'(imem_pc),  32'd10);
    check("t6_pre_valid", 32'(ir_valid), 32'd1);
    do_reset();
    check("t6_rst_valid", 32'(ir_valid), 32'd0);
    check("t6_rst_ir",    32'(ir),       32'd0);
    check("t6_rst_pc",    32'(imem_pc),  32'd0);
    cycle(1'b1, 1'b1, 1'b0, 16'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'd0);
    check("t6_refetch",   32'(ir_pc),    32'd0);
    check("t6_refetch_v", 32'(ir_valid), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        logic [15:0] rp;
        rp = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 23));
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) == 0, rp);
      end
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
